// File: rtl/retire_perf_monitor.sv
// Purpose : run monitor for the dual-issue core; counts cycles and retired
//           instructions, detects the end-of-test CSRRW, drains, then freezes.
// Latency : all outputs registered, 1 cycle from input sample to output.
// Backpressure: none; enable_i pauses counting, no flow control is exerted.
//
// Ports   : clk_i/rst_i (async active-high); enable_i gates counting;
//           pipe0/pipe1_retire_i retirement strobes; opcode_valid_i/opcode_i
//           exec0 opcode; cycle_count_o/instr_count_o counters; running_o,
//           halt_seen_o, done_o, timeout_o status.
// Option  : define RETIRE_MON_STALL_CNT_EN to add stall_count_o, counting
//           counted cycles in which neither pipe retired.
module retire_perf_monitor #(
    parameter int CNT_W          = 32,
    parameter int DRAIN_CYCLES   = 10,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             pipe0_retire_i,
    input  logic             pipe1_retire_i,
    input  logic             opcode_valid_i,
    input  logic [31:0]      opcode_i,
    output logic [CNT_W-1:0] cycle_count_o,
    output logic [CNT_W-1:0] instr_count_o,
`ifdef RETIRE_MON_STALL_CNT_EN
    output logic [CNT_W-1:0] stall_count_o,
`endif
    output logic             running_o,
    output logic             halt_seen_o,
    output logic             done_o,
    output logic             timeout_o
);

    // Drain counter needs at least one bit even when no drain is configured.
    localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0]    DRAIN_LD = DW'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] TMO_VAL  = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE, ST_TIMEOUT
    } state_t;

    state_t            state;
    logic [DW-1:0]     drain_cnt;
    logic              halt_evt;
    logic [CNT_W-1:0]  cyc_sat;
    logic [CNT_W:0]    ins_sum;
    logic [CNT_W-1:0]  ins_sat;
    logic              timeout_hit;
    logic              unused_opcode_bits;

    // CSRRW: SYSTEM major opcode with funct3 = 001.
    assign halt_evt = opcode_valid_i && (opcode_i[6:0] == 7'b1110011)
                      && (opcode_i[14:12] == 3'b001);
    assign unused_opcode_bits = ^{opcode_i[31:15], opcode_i[11:7]};

    // Saturating increments; counters stick at all-ones instead of wrapping.
    assign cyc_sat = (cycle_count_o == '1) ? cycle_count_o
                                            : cycle_count_o + CNT_W'(1);
    assign ins_sum = {1'b0, instr_count_o} + {{CNT_W{1'b0}}, pipe0_retire_i}
                     + {{CNT_W{1'b0}}, pipe1_retire_i};
    assign ins_sat = ins_sum[CNT_W] ? '1 : ins_sum[CNT_W-1:0];

    // Compared against the saturated value so an unreachable limit never fires.
    assign timeout_hit = (64'(cyc_sat) >= 64'(TIMEOUT_CYCLES));

`ifdef RETIRE_MON_STALL_CNT_EN
    logic [CNT_W-1:0] stall_sat;
    assign stall_sat = (stall_count_o == '1) ? stall_count_o
                                              : stall_count_o + CNT_W'(1);
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= ST_IDLE;
            drain_cnt     <= '0;
            cycle_count_o <= '0;
            instr_count_o <= '0;
`ifdef RETIRE_MON_STALL_CNT_EN
            stall_count_o <= '0;
`endif
            running_o     <= 1'b0;
            halt_seen_o   <= 1'b0;
            done_o        <= 1'b0;
            timeout_o     <= 1'b0;
        end else begin
            case (state)
                // The first enabled cycle in IDLE is already a counted run cycle.
                ST_IDLE, ST_RUN, ST_DRAIN: begin
                    if (enable_i) begin
                        instr_count_o <= ins_sat;
`ifdef RETIRE_MON_STALL_CNT_EN
                        if (!pipe0_retire_i && !pipe1_retire_i)
                            stall_count_o <= stall_sat;
`endif
                        if (timeout_hit) begin
                            // Timeout wins over halt detection and drain expiry.
                            cycle_count_o <= TMO_VAL;
                            state         <= ST_TIMEOUT;
                            running_o     <= 1'b0;
                            timeout_o     <= 1'b1;
                        end else begin
                            cycle_count_o <= cyc_sat;
                            running_o     <= 1'b1;
                            if (state != ST_DRAIN && halt_evt) begin
                                halt_seen_o <= 1'b1;
                                drain_cnt   <= DRAIN_LD;
                                if (DRAIN_CYCLES == 0) begin
                                    state     <= ST_DONE;
                                    running_o <= 1'b0;
                                    done_o    <= 1'b1;
                                end else begin
                                    state <= ST_DRAIN;
                                end
                            end else if (state == ST_DRAIN) begin
                                // Later halts are ignored; only the countdown matters.
                                drain_cnt <= drain_cnt - DW'(1);
                                if (drain_cnt == DW'(1)) begin
                                    state     <= ST_DONE;
                                    running_o <= 1'b0;
                                    done_o    <= 1'b1;
                                end
                            end else begin
                                state <= ST_RUN;
                            end
                        end
                    end
                end
                default: begin
                    // DONE and TIMEOUT are terminal until reset.
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_retire_perf_monitor.sv
// Bench for retire_perf_monitor: table-driven directed scenarios, hand-written
// corner sequences, and randomized stimulus checked against a behavioural model.
// Two instances: A (32-bit, drain 10, timeout 100) and B (6-bit, no drain).
module tb_retire_perf_monitor;

    localparam logic [31:0] HALT_OP = 32'h7C001073; // csrrw x0, 0x7c0, x0
    localparam logic [31:0] CSRS_OP = 32'h7C002073; // csrrs, not a halt
    localparam logic [31:0] NOP_OP  = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0, p0 = 1'b0, p1 = 1'b0, ov = 1'b0;
    logic [31:0] op = 32'h0;

    logic [31:0] a_cyc, a_ins;
    logic        a_run, a_hs, a_dn, a_to;
    logic [5:0]  b_cyc, b_ins;
    logic        b_run, b_hs, b_dn, b_to;
`ifdef RETIRE_MON_STALL_CNT_EN
    logic [31:0] a_stall;
    logic [5:0]  b_stall;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    retire_perf_monitor #(.CNT_W(32), .DRAIN_CYCLES(10), .TIMEOUT_CYCLES(100)) dut_a (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .pipe0_retire_i(p0),
        .pipe1_retire_i(p1), .opcode_valid_i(ov), .opcode_i(op),
        .cycle_count_o(a_cyc), .instr_count_o(a_ins),
`ifdef RETIRE_MON_STALL_CNT_EN
        .stall_count_o(a_stall),
`endif
        .running_o(a_run), .halt_seen_o(a_hs), .done_o(a_dn), .timeout_o(a_to));

    retire_perf_monitor #(.CNT_W(6), .DRAIN_CYCLES(0), .TIMEOUT_CYCLES(1000)) dut_b (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .pipe0_retire_i(p0),
        .pipe1_retire_i(p1), .opcode_valid_i(ov), .opcode_i(op),
        .cycle_count_o(b_cyc), .instr_count_o(b_ins),
`ifdef RETIRE_MON_STALL_CNT_EN
        .stall_count_o(b_stall),
`endif
        .running_o(b_run), .halt_seen_o(b_hs), .done_o(b_dn), .timeout_o(b_to));

    // ---------------- behavioural model ----------------
    // ph: 0 idle, 1 run, 2 drain, 3 done, 4 timeout
    typedef struct {
        int     ph;
        longint cyc, ins, stall;
        int     left;
        bit     hs;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.ph = 0; m.cyc = 0; m.ins = 0; m.stall = 0; m.left = 0; m.hs = 0;
        return m;
    endfunction

    function automatic mdl_t step(mdl_t m, int w, int drain, longint tmo,
                                  bit e, bit r0, bit r1, bit v, logic [31:0] o);
        longint mx = (longint'(1) << w) - 1;
        bit     halt = v && (o[6:0] == 7'h73) && (o[14:12] == 3'b001);
        longint nc;
        if (m.ph >= 3 || !e) return m;
        m.ins = m.ins + r0 + r1;
        if (m.ins > mx) m.ins = mx;
        if (!r0 && !r1 && m.stall < mx) m.stall = m.stall + 1;
        nc = (m.cyc < mx) ? m.cyc + 1 : mx;
        if (nc >= tmo) begin
            m.cyc = tmo;
            m.ph = 4;
            return m;
        end
        m.cyc = nc;
        if (m.ph == 0) m.ph = 1;
        if (m.ph == 1) begin
            if (halt) begin
                m.hs = 1;
                if (drain == 0) m.ph = 3;
                else begin
                    m.ph = 2;
                    m.left = drain;
                end
            end
        end else begin
            m.left = m.left - 1;
            if (m.left == 0) m.ph = 3;
        end
        return m;
    endfunction

    task automatic cmp(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic check_models();
        cmp("a_cyc_model", longint'(a_cyc), ma.cyc);
        cmp("a_ins_model", longint'(a_ins), ma.ins);
        cmp("a_run_model", longint'(a_run), longint'(ma.ph == 1 || ma.ph == 2));
        cmp("a_hs_model",  longint'(a_hs),  longint'(ma.hs));
        cmp("a_done_model", longint'(a_dn), longint'(ma.ph == 3));
        cmp("a_to_model",  longint'(a_to),  longint'(ma.ph == 4));
        cmp("b_cyc_model", longint'(b_cyc), mb.cyc);
        cmp("b_ins_model", longint'(b_ins), mb.ins);
        cmp("b_run_model", longint'(b_run), longint'(mb.ph == 1 || mb.ph == 2));
        cmp("b_hs_model",  longint'(b_hs),  longint'(mb.hs));
        cmp("b_done_model", longint'(b_dn), longint'(mb.ph == 3));
        cmp("b_to_model",  longint'(b_to),  longint'(mb.ph == 4));
`ifdef RETIRE_MON_STALL_CNT_EN
        cmp("a_stall_model", longint'(a_stall), ma.stall);
        cmp("b_stall_model", longint'(b_stall), mb.stall);
`endif
    endtask

    // Inputs are stable before the edge; models step at the edge, outputs
    // are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        ma = step(ma, 32, 10, 100, en, p0, p1, ov, op);
        mb = step(mb, 6, 0, 1000, en, p0, p1, ov, op);
        #1;
        check_models();
    endtask

    task automatic drive(input bit e, input bit r0, input bit r1, input bit h);
        en = e; p0 = r0; p1 = r1; ov = 1'b1;
        op = h ? HALT_OP : NOP_OP;
    endtask

    task automatic check_all_zero(input string tag);
        cmp({tag, "_a_cyc"}, longint'(a_cyc), 0);
        cmp({tag, "_a_ins"}, longint'(a_ins), 0);
        cmp({tag, "_a_flags"}, longint'({a_run, a_hs, a_dn, a_to}), 0);
        cmp({tag, "_b_cyc"}, longint'(b_cyc), 0);
        cmp({tag, "_b_flags"}, longint'({b_run, b_hs, b_dn, b_to}), 0);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0);
        rst = 1'b1;
        #7;
        check_all_zero("reset");
        ma = mdl_reset();
        mb = mdl_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int     n;          // 0 = apply reset
        bit     en, p0, p1, halt;
        longint cyc, ins;
        bit     run, hs, dn, to;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int n, bit e, bit r0, bit r1, bit h,
                                longint c, longint i, bit r, bit hs, bit d, bit t);
        vec_t v;
        v.n = n; v.en = e; v.p0 = r0; v.p1 = r1; v.halt = h;
        v.cyc = c; v.ins = i; v.run = r; v.hs = hs; v.dn = d; v.to = t;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ma = mdl_reset();
        mb = mdl_reset();

        // single pipe retiring, no halt
        tbl.push_back(mk(0, 0,0,0,0,  0,  0, 0,0,0,0));
        tbl.push_back(mk(20,1,1,0,0, 20, 20, 1,0,0,0));
        // dual retire, halt on cycle 11, drain to done, then frozen
        tbl.push_back(mk(0, 0,0,0,0,  0,  0, 0,0,0,0));
        tbl.push_back(mk(10,1,1,1,0, 10, 20, 1,0,0,0));
        tbl.push_back(mk(1, 1,0,0,1, 11, 20, 1,1,0,0));
        tbl.push_back(mk(9, 1,0,0,0, 20, 20, 1,1,0,0));
        tbl.push_back(mk(1, 1,0,0,0, 21, 20, 0,1,1,0));
        tbl.push_back(mk(50,1,1,1,0, 21, 20, 0,1,1,0));
        // second halt in drain does not restart it
        tbl.push_back(mk(0, 0,0,0,0,  0,  0, 0,0,0,0));
        tbl.push_back(mk(10,1,1,1,0, 10, 20, 1,0,0,0));
        tbl.push_back(mk(1, 1,0,0,1, 11, 20, 1,1,0,0));
        tbl.push_back(mk(4, 1,0,0,0, 15, 20, 1,1,0,0));
        tbl.push_back(mk(1, 1,0,0,1, 16, 20, 1,1,0,0));
        tbl.push_back(mk(4, 1,0,0,0, 20, 20, 1,1,0,0));
        tbl.push_back(mk(1, 1,0,0,0, 21, 20, 0,1,1,0));
        // timeout at 100, a halt on cycle 100 loses to timeout
        tbl.push_back(mk(0, 0,0,0,0,  0,  0, 0,0,0,0));
        tbl.push_back(mk(99,1,1,0,0, 99, 99, 1,0,0,0));
        tbl.push_back(mk(1, 1,1,0,1,100,100, 0,0,0,1));
        tbl.push_back(mk(10,1,1,1,0,100,100, 0,0,0,1));
        // enable low for cycles 5..9 of a 20-cycle window
        tbl.push_back(mk(0, 0,0,0,0,  0,  0, 0,0,0,0));
        tbl.push_back(mk(4, 1,1,0,0,  4,  4, 1,0,0,0));
        tbl.push_back(mk(5, 0,1,0,0,  4,  4, 1,0,0,0));
        tbl.push_back(mk(11,1,1,0,0, 15, 15, 1,0,0,0));

        foreach (tbl[k]) begin
            if (tbl[k].n == 0) begin
                do_reset();
            end else begin
                for (int c = 0; c < tbl[k].n; c++) begin
                    drive(tbl[k].en, tbl[k].p0, tbl[k].p1, tbl[k].halt);
                    tick();
                end
                cmp($sformatf("tbl%0d_cyc", k), longint'(a_cyc), tbl[k].cyc);
                cmp($sformatf("tbl%0d_ins", k), longint'(a_ins), tbl[k].ins);
                cmp($sformatf("tbl%0d_flags", k), longint'({a_run, a_hs, a_dn, a_to}),
                    longint'({tbl[k].run, tbl[k].hs, tbl[k].dn, tbl[k].to}));
            end
        end

        // zero-drain instance goes straight to done after the halt cycle
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(1, 1, 0, 0);
            tick();
        end
        drive(1, 1, 0, 1);
        tick();
        cmp("b_nodrain_done", longint'(b_dn), 1);
        cmp("b_nodrain_run", longint'(b_run), 0);
        cmp("b_nodrain_cyc", longint'(b_cyc), 4);
        cmp("a_drain_run", longint'(a_run), 1);
        drive(1, 1, 1, 0);
        tick();
        cmp("b_nodrain_frozen", longint'(b_cyc), 4);

        // saturation of the narrow instance
        do_reset();
        for (int c = 0; c < 70; c++) begin
            drive(1, 1, 1, 0);
            tick();
        end
        cmp("b_sat_cyc", longint'(b_cyc), 63);
        cmp("b_sat_ins", longint'(b_ins), 63);
        cmp("a_wide_cyc", longint'(a_cyc), 70);
        cmp("a_wide_ins", longint'(a_ins), 140);

        // asynchronous reset in the middle of drain
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive(1, 0, 1, 0);
            tick();
        end
        drive(1, 0, 0, 1);
        tick();
        drive(1, 1, 0, 0);
        tick();
        tick();
        tick();
        cmp("middrain_run", longint'(a_run), 1);
        cmp("middrain_hs", longint'(a_hs), 1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        ma = mdl_reset();
        mb = mdl_reset();
        @(negedge clk);
        rst = 1'b0;

`ifdef RETIRE_MON_STALL_CNT_EN
        do_reset();
        for (int c = 0; c < 8; c++) begin
            drive(1, (c % 2) == 0, 0, 0);
            tick();
        end
        cmp("stall_alt", longint'(a_stall), 4);
        cmp("stall_alt_ins", longint'(a_ins), 4);
`endif

        // randomized runs against the model
        for (int run = 0; run < 8; run++) begin
            do_reset();
            for (int c = 0; c < 150; c++) begin
                int r;
                en = ($urandom_range(0, 4) != 0);
                p0 = $urandom_range(0, 1);
                p1 = $urandom_range(0, 1);
                ov = ($urandom_range(0, 3) != 0);
                r = $urandom_range(0, 29);
                if (r == 0)      op = HALT_OP;
                else if (r == 1) op = CSRS_OP;
                else             op = $urandom;
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
